// File: rtl/cardinal_pkg.sv
// Shared constants for the cardinal NIC: register map, packet width and VC bit position.
package cardinal_pkg;

  localparam int unsigned DATA_WIDTH = 64;

  // Index of the virtual-channel bit within a packet (bit 0 is the MSB).
  localparam int unsigned VC_BIT = 0;

  typedef logic [1:0] nic_addr_t;

  localparam nic_addr_t NIC_ADDR_IBUF  = 2'b00;
  localparam nic_addr_t NIC_ADDR_ISTAT = 2'b01;
  localparam nic_addr_t NIC_ADDR_OBUF  = 2'b10;
  localparam nic_addr_t NIC_ADDR_OSTAT = 2'b11;

endpackage

// File: rtl/nic_chan_buf.sv
// One-entry packet buffer with a full flag. A load is accepted only while empty;
// clear empties the slot but keeps the data so a stale read still sees it.
module nic_chan_buf
  import cardinal_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [0:Width-1] load_data,
  output logic             full,
  output logic [0:Width-1] data
);

  // Slot state: clear wins over load; loads into a full slot are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load && !full) begin
      data <= load_data;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// CPU-facing NIC: memory-mapped register port on one side, router local port with
// send/ready handshake on the other. One packet buffered per direction.
module cardinal_nic
  import cardinal_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr_nic,
  input  logic [0:DATA_WIDTH-1] d_in,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  logic                  ib_full;
  logic                  ob_full;
  logic [0:DATA_WIDTH-1] ib_data;
  logic [0:DATA_WIDTH-1] ob_data;

  logic cpu_rd;
  logic cpu_wr;
  logic ib_load;
  logic ib_clear;
  logic ob_load;
  logic inject;

  assign cpu_rd = nicEn & ~nicWrEn;
  assign cpu_wr = nicEn & nicWrEn;

  // Router may only send while the input slot is empty.
  assign net_ri  = ~ib_full;
  assign ib_load = net_si & net_ri;

  // Reading the input buffer acknowledges the packet; stale reads have no effect.
  assign ib_clear = cpu_rd & (addr_nic == NIC_ADDR_IBUF) & ib_full;

  // Writes to a full output slot are dropped inside the buffer.
  assign ob_load = cpu_wr & (addr_nic == NIC_ADDR_OBUF);

  // Inject only on the VC opposite the router's current external polarity.
  assign inject = ob_full & net_ro & (ob_data[VC_BIT] != net_polarity);

  nic_chan_buf #(
    .Width (DATA_WIDTH)
  ) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .load      (ib_load),
    .clear     (ib_clear),
    .load_data (net_di),
    .full      (ib_full),
    .data      (ib_data)
  );

  nic_chan_buf #(
    .Width (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .load      (ob_load),
    .clear     (inject),
    .load_data (d_in),
    .full      (ob_full),
    .data      (ob_data)
  );

  // Router-side output registers: one-cycle send pulse, data held between packets.
  always_ff @(posedge clk) begin
    if (reset) begin
      net_so <= 1'b0;
      net_do <= '0;
    end else begin
      net_so <= inject;
      if (inject) begin
        net_do <= ob_data;
      end
    end
  end

  // Combinational CPU read mux; forced to zero during reset and on non-read cycles.
  always_comb begin
    d_out = '0;
    if (cpu_rd && !reset) begin
      case (addr_nic)
        NIC_ADDR_IBUF:  d_out = ib_data;
        NIC_ADDR_ISTAT: d_out = {{(DATA_WIDTH-1){1'b0}}, ib_full};
        NIC_ADDR_OBUF:  d_out = ob_data;
        NIC_ADDR_OSTAT: d_out = {{(DATA_WIDTH-1){1'b0}}, ob_full};
        default:        d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: stimulus queues expected read data and expected
// router packets; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cardinal_nic;

  logic        clk;
  logic        reset;
  logic [0:1]  addr_nic;
  logic [0:63] d_in;
  logic        nicEn;
  logic        nicWrEn;
  logic [0:63] d_out;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int errors = 0;
  int checks = 0;

  logic [63:0] rd_q[$];
  logic [63:0] tx_q[$];

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr_nic     (addr_nic),
    .d_in         (d_in),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .d_out        (d_out),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compare CPU read data and router-side packets against the queues.
  always @(negedge clk) begin
    if (nicEn && !nicWrEn) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 64'd1, 64'd0);
      end else begin
        check("cpu_read", d_out, rd_q.pop_front());
      end
    end
    if (net_so) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", net_do, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("net_do", net_do, tx_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [63:0] d);
    addr_nic = a;
    d_in     = d;
    nicEn    = 1'b1;
    nicWrEn  = 1'b1;
    cycle();
    nicEn    = 1'b0;
    nicWrEn  = 1'b0;
    d_in     = '0;
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [63:0] exp);
    rd_q.push_back(exp);
    addr_nic = a;
    nicEn    = 1'b1;
    nicWrEn  = 1'b0;
    cycle();
    nicEn    = 1'b0;
  endtask

  task automatic router_send(input logic [63:0] d);
    net_si = 1'b1;
    net_di = d;
    cycle();
    net_si = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; addr_nic = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    idle(2);

    // 1. Reset state
    check("rst_d_out", d_out, 64'h0);
    check("rst_net_ri", {63'b0, net_ri}, 64'h1);
    check("rst_net_so", {63'b0, net_so}, 64'h0);
    reset = 1'b0;
    cycle();
    cpu_read(2'b01, 64'h0);
    cpu_read(2'b11, 64'h0);

    // 2. Output path: VC bit 0 against polarity 1 injects right away
    net_ro = 1'b1; net_polarity = 1'b1;
    tx_q.push_back(64'h0123_4567_89AB_CDEF);
    cpu_write(2'b10, 64'h0123_4567_89AB_CDEF);
    cpu_read(2'b11, 64'h1);
    cpu_read(2'b11, 64'h0);
    idle(2);

    // 3. Polarity gating: VC bit equal to polarity holds; net_ro=0 also holds
    net_polarity = 1'b1;
    cpu_write(2'b10, 64'h8000_0000_0000_0001);
    cpu_read(2'b11, 64'h1);
    idle(2);
    cpu_read(2'b11, 64'h1);
    net_ro = 1'b0; net_polarity = 1'b0;
    idle(2);
    cpu_read(2'b11, 64'h1);
    tx_q.push_back(64'h8000_0000_0000_0001);
    net_ro = 1'b1;
    idle(2);
    cpu_read(2'b11, 64'h0);

    // 4. Input path, including an ignored send while full and ignored writes
    router_send(64'hDEAD_BEEF_0000_0042);
    check("ri_full", {63'b0, net_ri}, 64'h0);
    cpu_read(2'b01, 64'h1);
    router_send(64'h1111_2222_3333_4444);
    cpu_read(2'b00, 64'hDEAD_BEEF_0000_0042);
    check("ri_reopen", {63'b0, net_ri}, 64'h1);
    cpu_read(2'b01, 64'h0);
    cpu_write(2'b00, 64'h5555_5555_5555_5555);
    cpu_read(2'b00, 64'hDEAD_BEEF_0000_0042);
    check("ri_stale", {63'b0, net_ri}, 64'h1);

    // 5. Back-pressure: second write dropped while full
    net_ro = 1'b0; net_polarity = 1'b1;
    cpu_write(2'b10, 64'hAA);
    cpu_write(2'b10, 64'hBB);
    cpu_read(2'b10, 64'hAA);
    cpu_read(2'b11, 64'h1);
    tx_q.push_back(64'hAA);
    net_ro = 1'b1;
    idle(3);
    cpu_read(2'b11, 64'h0);
    check("so_idle", {63'b0, net_so}, 64'h0);

    // 6. Reset mid-operation with both buffers full
    net_ro = 1'b0;
    cpu_write(2'b10, 64'hCC);
    router_send(64'h77);
    reset = 1'b1;
    cpu_read(2'b10, 64'h0);
    reset = 1'b0;
    check("rst2_net_ri", {63'b0, net_ri}, 64'h1);
    check("rst2_net_so", {63'b0, net_so}, 64'h0);
    cpu_read(2'b01, 64'h0);
    cpu_read(2'b11, 64'h0);
    cpu_read(2'b00, 64'h0);
    cpu_read(2'b10, 64'h0);
    net_ro = 1'b1; net_polarity = 1'b1;
    idle(3);
    net_polarity = 1'b0;
    idle(3);

    check("tx_q_drained", 64'(tx_q.size()), 64'h0);
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
